exu: RTL and testbench

Execute/writeback stage of the small processing unit. Accepts two operand values read from the 4-entry register file (its `a`/`b` outputs) plus an opcode and destination index. Computes one of eight ALU operations, with multiply iterative over W cycles. Drives the register file's write port (`we`/`wad`/`wd`) for exactly one cycle per accepted operation.

---
 rtl/exu_if.sv | 28 ++
 rtl/exu.sv | 119 +++++++++++
 tb/tb_exu.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/exu_if.sv
// Request / writeback bundle between the issue logic, the execute stage and
// the register-file write port.
interface exu_if;
    localparam int WIDTH = 7;  // data MSB index
    localparam int RASB  = 1;  // register-address MSB index

    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH:0]   a;
    logic [WIDTH:0]   b;
    logic [RASB:0]    rd;
    logic             we;
    logic [RASB:0]    wad;
    logic [WIDTH:0]   wd;
    logic             zf;
    logic             cf;

    modport master (
        output in_valid, op, a, b, rd,
        input  in_ready, we, wad, wd, zf, cf
    );

    modport slave (
        input  in_valid, op, a, b, rd,
        output in_ready, we, wad, wd, zf, cf
    );
endinterface

// File: rtl/exu.sv
// Execute/writeback stage: eight unsigned ALU ops, single-cycle except MUL,
// which is a W-iteration shift-add. One write-port pulse per operation.
module exu (
    input  logic clk,
    input  logic rst,
    exu_if.slave bus
);
    localparam int WIDTH = 7;
    localparam int RASB  = 1;
    localparam int W     = WIDTH + 1;
    localparam int CW    = $clog2(W) + 1;

    typedef enum logic [1:0] {IDLE, MUL, WB} state_t;

    state_t         state, state_nxt;
    logic           accept, mul_last;
    logic [2*W-1:0] mcand, acc, acc_nxt;
    logic [W-1:0]   mplier, alu_res;
    logic [W:0]     sum;
    logic           alu_cf;
    logic [CW-1:0]  cnt;
    logic [RASB:0]  rd_q;

    assign accept   = bus.in_valid && bus.in_ready;
    assign mul_last = (cnt == CW'(W - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state: IDLE and WB both accept; MUL runs W iterations.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, WB: state_nxt = accept ? ((bus.op == 3'd7) ? MUL : WB) : IDLE;
            MUL:      if (mul_last) state_nxt = WB;
            default:  state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state; ready is forced low while in reset.
    always_comb begin
        bus.in_ready = !rst && (state != MUL);
        bus.we       = (state == WB);
    end

    // Single-cycle ALU, evaluated on the live inputs at the accept edge.
    always_comb begin
        alu_res = '0;
        alu_cf  = 1'b0;
        sum     = '0;
        case (bus.op)
            3'd0: begin
                sum     = {1'b0, bus.a} + {1'b0, bus.b};
                alu_res = sum[W-1:0];
                alu_cf  = sum[W];
            end
            3'd1: begin
                // The extra top bit becomes 1 exactly when a < b.
                sum     = {1'b0, bus.a} - {1'b0, bus.b};
                alu_res = sum[W-1:0];
                alu_cf  = sum[W];
            end
            3'd2: alu_res = bus.a & bus.b;
            3'd3: alu_res = bus.a | bus.b;
            3'd4: alu_res = bus.a ^ bus.b;
            3'd5: alu_res = (bus.b >= W'(W)) ? '0 : (bus.a << bus.b);
            3'd6: alu_res = (bus.b >= W'(W)) ? '0 : (bus.a >> bus.b);
            default: alu_res = '0;
        endcase
    end

    // One shift-add step: multiplicand is shifted by the iteration count.
    always_comb begin
        acc_nxt = acc;
        if (mplier[0]) acc_nxt = acc + (mcand << cnt);
    end

    // Datapath: result/flag registers only move on a writeback-producing edge,
    // so wad/wd/zf/cf hold their last values while we is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.wad <= '0;
            bus.wd  <= '0;
            bus.zf  <= 1'b0;
            bus.cf  <= 1'b0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            rd_q    <= '0;
        end else if (accept) begin
            if (bus.op != 3'd7) begin
                bus.wad <= bus.rd;
                bus.wd  <= alu_res;
                bus.zf  <= (alu_res == '0);
                bus.cf  <= alu_cf;
            end else begin
                mcand  <= {{W{1'b0}}, bus.a};
                mplier <= bus.b;
                acc    <= '0;
                cnt    <= '0;
                rd_q   <= bus.rd;
            end
        end else if (state == MUL) begin
            acc    <= acc_nxt;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (mul_last) begin
                bus.wad <= rd_q;
                bus.wd  <= acc_nxt[W-1:0];
                bus.zf  <= (acc_nxt[W-1:0] == '0);
                bus.cf  <= (acc_nxt[2*W-1:W] != '0);
            end
        end
    end
endmodule

// File: tb/tb_exu.sv
// Randomized + directed bench for exu against a transaction-level model:
// each accepted op is scored with plain integer arithmetic and a due cycle
// derived from the documented latencies (1 for ALU ops, W+1 for MUL).
module tb_exu;
    localparam int W    = 8;
    localparam int MODV = 1 << W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exu_if ifc ();

    exu dut (.clk(clk), .rst(rst), .bus(ifc));

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int rd;
        int res;
        int cf;
    } wb_t;

    wb_t q[$];
    int  cyc = 0;
    int  mul_end = 0;
    int  n_chk = 0;
    int  n_pass = 0;
    int  last_wad = 0, last_wd = 0, last_zf = 0, last_cf = 0;
    bit  accepted;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    endtask

    function automatic void ref_alu(input int op, input int a, input int b,
                                    output int res, output int cf);
        int p;
        cf = 0;
        case (op)
            0: begin p = a + b; res = p % MODV; cf = (p >= MODV); end
            1: begin res = (a - b + MODV) % MODV; cf = (a < b); end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: res = (b >= W) ? 0 : ((a << b) % MODV);
            6: res = (b >= W) ? 0 : (a >> b);
            default: begin p = a * b; res = p % MODV; cf = (p >= MODV); end
        endcase
    endfunction

    // One clock: check outputs mid-cycle, score an accept, advance the edge.
    task automatic tick();
        bit rst_edge;
        wb_t e;
        @(negedge clk);
        if (rst) begin
            chk("ready_in_rst", ifc.in_ready, 0);
        end else begin
            chk("ready", ifc.in_ready, (cyc >= mul_end));
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                chk("we", ifc.we, 1);
                chk("wad", ifc.wad, e.rd);
                chk("wd", ifc.wd, e.res);
                chk("zf", ifc.zf, (e.res == 0));
                chk("cf", ifc.cf, e.cf);
                last_wad = e.rd; last_wd = e.res;
                last_zf = (e.res == 0); last_cf = e.cf;
            end else begin
                chk("we_idle", ifc.we, 0);
                chk("wad_hold", ifc.wad, last_wad);
                chk("wd_hold", ifc.wd, last_wd);
                chk("zf_hold", ifc.zf, last_zf);
                chk("cf_hold", ifc.cf, last_cf);
            end
        end
        accepted = !rst && ifc.in_valid && (cyc >= mul_end);
        if (accepted) begin
            e.rd = ifc.rd;
            ref_alu(ifc.op, ifc.a, ifc.b, e.res, e.cf);
            if (ifc.op == 3'd7) begin
                e.due = cyc + 1 + W;
                mul_end = cyc + 1 + W;
            end else begin
                e.due = cyc + 1;
            end
            q.push_back(e);
        end
        rst_edge = rst;
        @(posedge clk);
        cyc++;
        if (rst_edge) begin
            q.delete();
            mul_end = 0;
            last_wad = 0; last_wd = 0; last_zf = 0; last_cf = 0;
        end
        #1;
    endtask

    task automatic send(input int op, input int a, input int b, input int rd);
        ifc.in_valid = 1'b1;
        ifc.op = 3'(op);
        ifc.a  = 8'(a);
        ifc.b  = 8'(b);
        ifc.rd = 2'(rd);
        for (int i = 0; i < 3 * W; i++) begin
            tick();
            if (accepted) return;
        end
        chk("accept_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            ifc.in_valid = 1'b0;
            ifc.op = 3'($urandom);
            ifc.a  = 8'($urandom);
            ifc.b  = 8'($urandom);
            ifc.rd = 2'($urandom);
            tick();
        end
    endtask

    initial begin
        ifc.in_valid = 1'b0;
        ifc.op = '0; ifc.a = '0; ifc.b = '0; ifc.rd = '0;
        rst = 1'b1;
        @(posedge clk); #1;
        tick(); tick();            // two reset cycles
        rst = 1'b0;
        idle(2);                   // reset values, ready right after release

        send(0, 8'hF0, 8'h20, 2);  // ADD with carry
        send(1, 5, 5, 0);          // SUB to zero
        idle(2);

        send(4, 8'hAA, 8'hFF, 1);  // back-to-back XOR/SHL/SHR
        send(5, 8'h81, 1, 3);
        send(6, 8'h80, 9, 0);
        idle(2);

        send(7, 13, 11, 1);        // MUL
        idle(W + 2);
        send(7, 8'h10, 8'h10, 2);  // MUL overflow, zero result
        idle(W + 2);

        send(7, 8'hFF, 8'hFF, 3);  // abort mid-MUL
        idle(3);
        rst = 1'b1;
        ifc.in_valid = 1'b0;
        tick();
        rst = 1'b0;
        idle(W + 2);               // no stray writeback
        send(0, 1, 1, 2);
        idle(2);

        send(7, 7, 9, 1);          // request held during MUL
        send(2, 8'hF0, 8'h3C, 3);
        idle(3);

        for (int i = 0; i < 300; i++) begin
            int op, b;
            op = $urandom_range(0, 7);
            b  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 10) : $urandom_range(0, 255);
            send(op, $urandom_range(0, 255), b, $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            if ($urandom_range(0, 60) == 0) begin
                rst = 1'b1;
                ifc.in_valid = 1'b0;
                tick();
                rst = 1'b0;
            end
        end
        idle(W + 3);
        chk("queue_drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
